// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// opcodes, immediate formats, FSM states, instruction classes and
// the PC / write-back mux select codes.
package rv32_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate generator format select
  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  // PC source select
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_ALU     = 2'd1;
  localparam logic [1:0] PC_ALU_CLR = 2'd2;

  // Register file write-back select
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_OPIMM  = 4'd7,
    CLS_OP     = 4'd8
  } cls_t;

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Opcode decoder: maps instr[6:0] to the immediate format, the
// instruction class used by the sequencer, and a legal flag.
module rv32_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] ext_op_o,
  output cls_t       cls_o,
  output logic       legal_o
);

  // Pure table lookup; unknown opcodes fall to illegal with I-format defaults.
  always_comb begin
    ext_op_o = EXT_I;
    cls_o    = CLS_OP;
    legal_o  = 1'b1;
    case (opcode_i)
      OPC_LUI:    begin ext_op_o = EXT_U; cls_o = CLS_LUI;    end
      OPC_AUIPC:  begin ext_op_o = EXT_U; cls_o = CLS_AUIPC;  end
      OPC_JAL:    begin ext_op_o = EXT_J; cls_o = CLS_JAL;    end
      OPC_JALR:   begin ext_op_o = EXT_I; cls_o = CLS_JALR;   end
      OPC_BRANCH: begin ext_op_o = EXT_B; cls_o = CLS_BRANCH; end
      OPC_LOAD:   begin ext_op_o = EXT_I; cls_o = CLS_LOAD;   end
      OPC_STORE:  begin ext_op_o = EXT_S; cls_o = CLS_STORE;  end
      OPC_OPIMM:  begin ext_op_o = EXT_I; cls_o = CLS_OPIMM;  end
      OPC_OP:     begin ext_op_o = EXT_I; cls_o = CLS_OP;     end
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
//
// Memory handshake: mem_req is the valid and mem_ready the ready of a
// single outstanding access. mem_req, mem_we and mem_addr_sel are pure
// functions of the state, so they stay stable until the cycle in which
// mem_ready is seen high; that cycle completes the access. mem_ready is
// ignored whenever mem_req is low. Reset abandons any access at once.
module rv32_mc_ctrl
  import rv32_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  ExtOp,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t      state_q, state_d;
  logic [2:0]  ext_q, ext_d;
  cls_t        cls_q, cls_d;

  logic [2:0]  dec_ext;
  cls_t        dec_cls;
  logic        dec_legal;

  logic        req_c, we_c, addr_sel_c, ir_we_c, pc_we_c, rf_we_c;
  logic [1:0]  pc_src_c, wb_sel_c;

  // Operand/immediate bits are consumed by the datapath, not by control.
  logic        unused_instr_hi;
  assign unused_instr_hi = ^instr[31:7];

  rv32_ctrl_decode u_decode (
    .opcode_i (instr[6:0]),
    .ext_op_o (dec_ext),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  // State, latched immediate format and instruction class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ext_q   <= EXT_I;
      cls_q   <= CLS_OP;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      cls_q   <= cls_d;
    end
  end

  // Next state and per-state control strobes.
  always_comb begin
    state_d    = state_q;
    ext_d      = ext_q;
    cls_d      = cls_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_src_c   = PC_PLUS4;
    rf_we_c    = 1'b0;
    wb_sel_c   = WB_ALU;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ext_d   = dec_ext;
        cls_d   = dec_cls;
        state_d = (dec_legal && (instr[1:0] == 2'b11)) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_JAL: begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_ALU;
            state_d  = S_WB;
          end
          CLS_JALR: begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_ALU_CLR;
            state_d  = S_WB;
          end
          CLS_BRANCH: begin
            pc_we_c  = br_taken;
            pc_src_c = PC_ALU;
            state_d  = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        req_c      = 1'b1;
        addr_sel_c = 1'b1;
        we_c       = (cls_q == CLS_STORE);
        if (mem_ready) state_d = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we_c = 1'b1;
        case (cls_q)
          CLS_LUI:            wb_sel_c = WB_IMM;
          CLS_LOAD:           wb_sel_c = WB_LOAD;
          CLS_JAL, CLS_JALR:  wb_sel_c = WB_PC4;
          default:            wb_sel_c = WB_ALU;
        endcase
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // ALU operand selects held from EXEC through WB so the ALU result stays valid.
  always_comb begin
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        CLS_AUIPC, CLS_JAL, CLS_BRANCH: begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end
        CLS_OP:  alu_b_sel = 1'b0;
        default: alu_b_sel = 1'b1;
      endcase
    end
  end

  // Strobes and the request are forced low for the whole reset assertion.
  assign mem_req      = req_c & rst_n;
  assign mem_we       = we_c & rst_n;
  assign mem_addr_sel = addr_sel_c;
  assign ir_we        = ir_we_c & rst_n;
  assign pc_we        = pc_we_c & rst_n;
  assign rf_we        = rf_we_c & rst_n;
  assign pc_src       = pc_src_c;
  assign wb_sel       = wb_sel_c;
  assign ExtOp        = ext_q;
  assign illegal      = (state_q == S_TRAP);
  assign state        = state_q;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Bench for rv32_mc_ctrl: per-cycle expected output vectors are queued
// together with the instruction/branch/ready stimulus for that cycle,
// then popped and compared at the falling edge.
module tb_rv32_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic [1:0]  pc_src, wb_sel;
  logic        alu_a_sel, alu_b_sel, illegal;
  logic [2:0]  ExtOp, state;

  // {state, req, we, asel, ir_we, pc_we, pc_src, rf_we, wb_sel, a, b, ExtOp, illegal}
  logic [18:0] obs;
  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                rf_we, wb_sel, alu_a_sel, alu_b_sel, ExtOp, illegal};

  logic [18:0] exp_q[$];
  logic [18:0] msk_q[$];
  logic [31:0] ins_q[$];
  logic        br_q[$];
  logic        rdy_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  prev_ext;

  rv32_mc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .ExtOp        (ExtOp),
    .illegal      (illegal),
    .state        (state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Driver: queue one cycle of stimulus plus its expected outputs and care mask.
  task automatic push_cycle(input logic [31:0] ins, input logic br, input logic rdy,
                            input logic [2:0] st, input logic req, input logic we,
                            input logic asel, input logic irw, input logic pcw,
                            input logic [1:0] pcs, input logic rf, input logic [1:0] wbs,
                            input logic ac, input logic a, input logic b,
                            input logic [2:0] ext, input logic ill);
    logic [18:0] m;
    m = '1;
    if (!req)        m[14:13] = 2'b00;
    if (!pcw)        m[10:9]  = 2'b00;
    if (!rf)         m[7:6]   = 2'b00;
    if (!ac)         m[5:4]   = 2'b00;
    if (st == 3'd5)  m[3:1]   = 3'b000;
    exp_q.push_back({st, req, we, asel, irw, pcw, pcs, rf, wbs, a, b, ext, ill});
    msk_q.push_back(m);
    ins_q.push_back(ins);
    br_q.push_back(br);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_fetch(input logic [31:0] ins, input logic rdy);
    push_cycle(ins, 1'b0, rdy, 3'd0, 1'b1, 1'b0, 1'b0, rdy, rdy, 2'd0,
               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, prev_ext, 1'b0);
  endtask

  // mem_ready is randomised here: no request is outstanding, so it must be ignored.
  task automatic push_decode(input logic [31:0] ins);
    logic r;
    r = 1'($urandom_range(0, 1));
    push_cycle(ins, 1'b0, r, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, prev_ext, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; instr = 32'h0; br_taken = 1'b0; mem_ready = 1'b1;
    prev_ext = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++;
    if ({ir_we, pc_we, rf_we, mem_we} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000", {ir_we, pc_we, rf_we, mem_we});
    end
    n_cmp++;
    if ({ExtOp, illegal} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ext_illegal: got %b want 0000", {ExtOp, illegal});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lui;
    logic [18:0] ev, mv;
    int cyc;
    cyc = 0;
    push_fetch(32'h000120B7, 1'b1);
    push_decode(32'h000120B7);
    prev_ext = 3'b001;
    push_cycle(32'h000120B7, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    push_cycle(32'h000120B7, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL lui cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    logic [18:0] ev, mv;
    int cyc;
    cyc = 0;
    for (int t = 1; t >= 0; t--) begin
      push_fetch(32'h00208463, 1'b1);
      push_decode(32'h00208463);
      prev_ext = 3'b011;
      push_cycle(32'h00208463, 1'(t), 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'(t), 2'd1,
                 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0);
    end
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL branch cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait;
    logic [18:0] ev, mv;
    int cyc;
    cyc = 0;
    push_fetch(32'h0040A103, 1'b1);
    push_decode(32'h0040A103);
    prev_ext = 3'b000;
    push_cycle(32'h0040A103, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    for (int w = 0; w < 3; w++)
      push_cycle(32'h0040A103, 1'b0, (w == 2), 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0,
                 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    push_cycle(32'h0040A103, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL load_wait cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [18:0] ev, mv;
    int cyc;
    cyc = 0;
    // sw with one fetch wait state
    push_fetch(32'h0020A223, 1'b0);
    push_fetch(32'h0020A223, 1'b1);
    push_decode(32'h0020A223);
    prev_ext = 3'b010;
    push_cycle(32'h0020A223, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0);
    push_cycle(32'h0020A223, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
    // jal immediately after
    push_fetch(32'h008000EF, 1'b1);
    push_decode(32'h008000EF);
    prev_ext = 3'b100;
    push_cycle(32'h008000EF, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1,
               1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0);
    push_cycle(32'h008000EF, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL back_to_back cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops;
    logic [18:0] ev, mv;
    int cyc;
    logic [31:0] t_ins [4] = '{32'h002081B3, 32'h00108093, 32'h00001097, 32'h000080E7};
    logic [2:0]  t_ext [4] = '{3'b000, 3'b000, 3'b001, 3'b000};
    logic        t_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_b   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        t_pcw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_wbs [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      push_fetch(t_ins[k], 1'b1);
      push_decode(t_ins[k]);
      prev_ext = t_ext[k];
      push_cycle(t_ins[k], 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, t_pcw[k], 2'd2,
                 1'b0, 2'd0, 1'b1, t_a[k], t_b[k], t_ext[k], 1'b0);
      push_cycle(t_ins[k], 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                 1'b1, t_wbs[k], 1'b0, 1'b0, 1'b0, t_ext[k], 1'b0);
    end
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL alu_ops cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [18:0] ev, mv;
    int cyc;
    logic r;
    cyc = 0;
    push_fetch(32'h0000007F, 1'b1);
    push_decode(32'h0000007F);
    for (int k = 0; k < 6; k++) begin
      r = 1'($urandom_range(0, 1));
      push_cycle(32'h0000007F, 1'b0, r, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    end
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL illegal cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [18:0] ev, mv;
    int cyc;
    cyc = 0;
    // leave TRAP
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_ext = 3'b000;
    push_fetch(32'h0040A103, 1'b1);
    push_decode(32'h0040A103);
    push_cycle(32'h0040A103, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    push_cycle(32'h0040A103, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0,
               1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL reset_mid_mem cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
    // Still in MEM waiting; assert reset mid-access.
    n_cmp++;
    if (mem_req !== 1'b1 || state !== 3'd3) begin
      n_err++; $display("FAIL mid_mem_pending: got req=%b state=%0d want req=1 state=3", mem_req, state);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_mem_req_drop: got %b want 0", mem_req); end
    n_cmp++;
    if (state !== 3'd0) begin n_err++; $display("FAIL mid_mem_state: got %0d want 0", state); end
    n_cmp++;
    if ({ExtOp, illegal} !== 4'b0000) begin
      n_err++; $display("FAIL mid_mem_ext: got %b want 0000", {ExtOp, illegal});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    push_fetch(32'h0040A103, 1'b0);
    push_fetch(32'h0040A103, 1'b1);
    while (exp_q.size() != 0) begin
      instr = ins_q.pop_front(); br_taken = br_q.pop_front(); mem_ready = rdy_q.pop_front();
      ev = exp_q.pop_front(); mv = msk_q.pop_front();
      @(negedge clk);
      n_cmp++;
      if ((obs & mv) !== (ev & mv)) begin
        n_err++; $display("FAIL reissue cyc%0d: got %b want %b mask %b", cyc, obs, ev, mv);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_lui();
    test_branch();
    test_load_wait();
    test_back_to_back();
    test_alu_ops();
    test_illegal();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_mc_ctrl.md
# rv32_mc_ctrl

Multi-cycle control sequencer for the RV32I core. It owns the FETCH/DECODE/EXEC/MEM/WB state machine and the memory request handshake. It drives the 3-bit ExtOp select of the immediate generator plus all datapath write enables and mux selects. It sits between the instruction register/branch comparator and the shared single-port memory, register file, PC and ALU.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  current instruction from IR
- br_taken  in  1  branch comparator result for the instruction in IR (funct3-qualified by datapath)
- mem_ready  in  1  memory completes the pending access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  store request (valid with mem_req)
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_we  out  1  latch instr and old_pc
- pc_we  out  1  PC write strobe
- pc_src  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- rf_we  out  1  register file write strobe
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = old_pc+4, 3 = Imm
- alu_a_sel  out  1  0 = rs1, 1 = old_pc
- alu_b_sel  out  1  0 = rs2, 1 = Imm
- ExtOp  out  3  immediate format: 000 I, 001 U, 010 S, 011 B, 100 J
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ready=1, pulse ir_we=1 and pc_we=1 with pc_src=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: register ExtOp from instr[6:0]. The register holds its value until the next DECODE.
- DECODE next-state: illegal opcode, or instr[1:0]!=11 -> TRAP; otherwise -> EXEC.
- Opcode map:
  - LUI 0110111: ExtOp U; EXEC idle; WB with wb_sel=3.
  - AUIPC 0010111: ExtOp U; EXEC a=old_pc, b=Imm; WB with wb_sel=0.
  - JAL 1101111: ExtOp J; EXEC a=old_pc, b=Imm, pc_we with pc_src=1; WB with wb_sel=2.
  - JALR 1100111: ExtOp I; EXEC a=rs1, b=Imm, pc_we with pc_src=2; WB with wb_sel=2.
  - BRANCH 1100011: ExtOp B; EXEC a=old_pc, b=Imm, pc_we=br_taken with pc_src=1; then FETCH, no WB.
  - LOAD 0000011: ExtOp I; EXEC a=rs1, b=Imm; MEM (read); WB with wb_sel=1.
  - STORE 0100011: ExtOp S; EXEC as LOAD; MEM with mem_we=1; then FETCH.
  - OP-IMM 0010011: ExtOp I; EXEC b=Imm; WB with wb_sel=0.
  - OP 0110011: ExtOp 000; EXEC b=rs2; WB with wb_sel=0.
- MEM: mem_req=1, mem_addr_sel=1. Stay in MEM until mem_ready. For loads the data is captured by the datapath on the ready cycle.
- WB: rf_we=1 for one cycle, then FETCH.
- TRAP: terminal. illegal=1, all strobes 0, mem_req=0. Leaves TRAP only on reset.

## Timing
- Reset (async, immediate): state=FETCH, ExtOp=000, illegal=0. All strobes and mem_req are 0 while rst_n=0.
- mem_req is asserted combinationally from state. The first FETCH after rst_n deassertion requests on the first clock.
- ExtOp is registered and valid from the EXEC cycle onward. It is stable through MEM and WB.
- Cycle counts with zero wait states (mem_ready=1 on first request cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each wait cycle adds one cycle in FETCH or MEM.
- mem_ready while mem_req=0 is ignored.
- mem_we, mem_addr_sel and the address select stay stable while waiting for mem_ready.
- All strobes (ir_we, pc_we, rf_we) are single-cycle pulses; none is asserted twice per instruction except pc_we (FETCH and EXEC).
- Reset asserted mid-access drops mem_req in the same cycle. The memory must tolerate an abandoned request.

## Structure
- Package rv32_ctrl_pkg holds:
  - opcode constants
  - ExtOp encodings (EXT_I=000, EXT_U=001, EXT_S=010, EXT_B=011, EXT_J=100)
  - state enum
  - pc_src and wb_sel encodings
- Sub-module rv32_ctrl_decode (combinational) maps instr[6:0] to {ext_op, instruction class, legal}. The FSM registers the result in DECODE.

## Test plan
- Reset sequencing: assert rst_n=0 mid-MEM with mem_req=1 -> mem_req=0, state=0, ExtOp=000 in the same cycle; the first request reissues after release.
- LUI x1 (0x000120B7), zero-wait memory -> ExtOp=001; states 0,1,2,4; rf_we pulses in cycle 4 with wb_sel=3.
- BRANCH beq (0x00208463):
  - br_taken=1 -> ExtOp=011, pc_we in EXEC with pc_src=1, back to FETCH after 3 cycles, rf_we never asserted.
  - br_taken=0 -> no EXEC pc_we.
- LOAD lw (0x0040A103), mem_ready low for 2 MEM cycles -> ExtOp=000, mem_addr_sel=1 held, 7 cycles total, rf_we with wb_sel=1.
- STORE sw (0x0020A223) then JAL (0x008000EF):
  - sw -> ExtOp=010, mem_we=1 in MEM only.
  - jal -> ExtOp=100, pc_src=1 in EXEC, wb_sel=2 in WB.
- Illegal opcode 0x0000007F -> TRAP, illegal=1 sticky, no further mem_req until reset.
